// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared constants for the Booth multiplier datapath
//
// Purpose: operand width, iteration counter width, last-iteration value and
// the accumulator/multiplicand width. That width grows by one guard bit
// when BOOTH_DP_GUARD_BIT_EN is defined, which makes -128 operands exact.
// Ports: none (package).
package booth_pkg;
  localparam int WIDTH = 8;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_CNT = 3'd7;
`ifdef BOOTH_DP_GUARD_BIT_EN
  localparam int A_W = WIDTH + 1;
`else
  localparam int A_W = WIDTH;
`endif
endpackage

// File: rtl/booth_addsub.sv
// rtl/booth_addsub.sv - combinational accumulator adder/subtractor
//
// Purpose: sum = a + m, or a - m when sub is high. The result is truncated
// to W bits and the carry is discarded.
// Ports: a, m (W bits), sub (1) -> sum (W bits).
module booth_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] m,
  input  logic         sub,
  output logic [W-1:0] sum
);
  assign sum = sub ? (a - m) : (a + m);
endmodule

// File: rtl/booth_datapath.sv
// rtl/booth_datapath.sv - Booth radix-2 multiplier datapath (A, Q, Q-1, M, cnt)
//
// Purpose: holds the registers of a Booth multiplier. An external control
// unit drives the strobes c0..c6.
// Optional feature: BOOTH_DP_GUARD_BIT_EN widens A and M to 9 bits.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   inbus[7:0]     operand bus (multiplier on c0, multiplicand on c1)
//   c0..c6         load Q / load M / add-sub / subtract / shift / drive A / drive Q
//   q0, q_1        Q[0] and Q[-1] for the control unit
//   count7         iteration counter currently equals 7
//   outbus[7:0]    A[7:0] on c5, Q on c6, else zero
module booth_datapath
  import booth_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inbus,
  input  logic             c0,
  input  logic             c1,
  input  logic             c2,
  input  logic             c3,
  input  logic             c4,
  input  logic             c5,
  input  logic             c6,
  output logic             q0,
  output logic             q_1,
  output logic             count7,
  output logic [WIDTH-1:0] outbus
);
  logic [A_W-1:0]   a_q, a_d;
  logic [A_W-1:0]   m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_m1_q, q_m1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [A_W-1:0]   sum;

  booth_addsub #(.W(A_W)) u_addsub (
    .a   (a_q),
    .m   (m_q),
    .sub (c3),
    .sum (sum)
  );

  // Strobes form a strict priority chain: c0 > c1 > c2 > c4. c3 only
  // steers the adder, so on its own it changes nothing.
  always_comb begin
    a_d    = a_q;
    m_d    = m_q;
    q_d    = q_q;
    q_m1_d = q_m1_q;
    cnt_d  = cnt_q;
    if (c0) begin
      a_d    = '0;
      q_d    = inbus;
      q_m1_d = 1'b0;
      cnt_d  = '0;
    end else if (c1) begin
      m_d = A_W'($signed(inbus));
    end else if (c2) begin
      a_d = sum;
    end else if (c4) begin
      // Arithmetic right shift of {A,Q,Q-1}: the A sign bit is replicated.
      {a_d, q_d, q_m1_d} = {a_q[A_W-1], a_q, q_q};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      m_q    <= '0;
      q_q    <= '0;
      q_m1_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      m_q    <= m_d;
      q_q    <= q_d;
      q_m1_q <= q_m1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q0     = q_q[0];
  assign q_1    = q_m1_q;
  assign count7 = (cnt_q == LAST_CNT);
  assign outbus = c5 ? a_q[WIDTH-1:0] : (c6 ? q_q : '0);
endmodule

// File: tb/tb_booth_datapath.sv
// tb/tb_booth_datapath.sv - self-checking bench for booth_datapath
module tb_booth_datapath;
  import booth_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] inbus = 8'h00;
  logic [6:0] c = 7'h00;
  logic       q0, q_1, count7;
  logic [7:0] outbus;

  int checks = 0;
  int errors = 0;

  // Behavioural model: signed integers for A and M, plain values for the rest.
  int ma = 0, mm = 0, mq = 0, mqm1 = 0, mcnt = 0;

  booth_datapath dut (
    .clk    (clk),
    .rst    (rst),
    .inbus  (inbus),
    .c0     (c[0]),
    .c1     (c[1]),
    .c2     (c[2]),
    .c3     (c[3]),
    .c4     (c[4]),
    .c5     (c[5]),
    .c6     (c[6]),
    .q0     (q0),
    .q_1    (q_1),
    .count7 (count7),
    .outbus (outbus)
  );

  always #5 clk = ~clk;

  function automatic int wrapa(input int v);
    int w;
    w = v & ((1 << A_W) - 1);
    if (w >= (1 << (A_W - 1))) w -= (1 << A_W);
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    longint comb;
    if (rst) begin
      ma = 0; mm = 0; mq = 0; mqm1 = 0; mcnt = 0;
    end else if (c[0]) begin
      ma = 0; mq = int'(inbus); mqm1 = 0; mcnt = 0;
    end else if (c[1]) begin
      mm = int'($signed(inbus));
    end else if (c[2]) begin
      ma = wrapa(c[3] ? ma - mm : ma + mm);
    end else if (c[4]) begin
      comb = longint'(ma) * 512 + longint'(mq) * 2 + longint'(mqm1);
      comb = comb >>> 1;
      mqm1 = int'(comb & 1);
      mq   = int'((comb >>> 1) & 255);
      ma   = int'(comb >>> 9);
      mcnt = (mcnt + 1) % 8;
    end
  endtask

  // One clock: compare every output against the model at the falling edge,
  // optionally against hand-computed literals (-1 = no literal), then let the
  // model take the same edge as the DUT.
  task automatic tick(input int p_out, input int p_c7, input int p_q0, input int p_q1,
                      input string nm);
    int exp_out;
    @(negedge clk);
    exp_out = c[5] ? (ma & 255) : (c[6] ? mq : 0);
    chk("model_outbus", 32'(outbus), 32'(exp_out));
    chk("model_q0", 32'(q0), 32'(mq & 1));
    chk("model_q_1", 32'(q_1), 32'(mqm1));
    chk("model_count7", 32'(count7), 32'(mcnt == 7));
    if (p_out >= 0) chk({nm, "_outbus"}, 32'(outbus), 32'(p_out));
    if (p_c7 >= 0) chk({nm, "_count7"}, 32'(count7), 32'(p_c7));
    if (p_q0 >= 0) chk({nm, "_q0"}, 32'(q0), 32'(p_q0));
    if (p_q1 >= 0) chk({nm, "_q_1"}, 32'(q_1), 32'(p_q1));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic [6:0] cv, input logic [7:0] bus);
    c = cv;
    inbus = bus;
  endtask

  // Full multiply in the style of the Booth control unit, steered by the
  // model's Q[0]/Q[-1]. exp_hi/exp_lo < 0 means no product literal.
  task automatic mult(input logic [7:0] x, input logic [7:0] y,
                      input int exp_hi, input int exp_lo, input string nm);
    drive(7'b0000001, x); tick(-1, -1, -1, -1, nm);
    drive(7'b0000010, y); tick(-1, -1, -1, -1, nm);
    for (int i = 0; i < 8; i++) begin
      if ((mq & 1) == 1 && mqm1 == 0) begin
        drive(7'b0001100, $urandom_range(0, 255)); tick(-1, -1, -1, -1, nm);
      end else if ((mq & 1) == 0 && mqm1 == 1) begin
        drive(7'b0000100, $urandom_range(0, 255)); tick(-1, -1, -1, -1, nm);
      end
      drive(7'b0010000, 8'h00); tick(-1, (i == 7) ? 1 : 0, -1, -1, {nm, "_shift"});
    end
    drive(7'b0100000, 8'h00); tick(exp_hi, -1, -1, -1, {nm, "_hi"});
    drive(7'b1000000, 8'h00); tick(exp_lo, -1, -1, -1, {nm, "_lo"});
    drive(7'b0000000, 8'h00);
  endtask

  task automatic mult_arith(input logic [7:0] x, input logic [7:0] y, input string nm);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    mult(x, y, (p >> 8) & 255, p & 255, nm);
  endtask

  initial begin
    logic [7:0] x, y;
    rst = 1'b1;
    @(posedge clk);
    model_update();
    #1;

    // Reset state, with reset still high.
    drive(7'b0100000, 8'hAA); tick(0, 0, 0, 0, "reset_a");
    drive(7'b1000000, 8'h55); tick(0, 0, 0, 0, "reset_q");
    rst = 1'b0;
    drive(7'b0000000, 8'h00); tick(0, 0, 0, 0, "idle");

    // Directed products.
    mult(8'd5, 8'd3, 8'h00, 8'h0F, "mul_5x3");
    mult(8'hF9, 8'd6, 8'hFF, 8'hD6, "mul_m7x6");
`ifdef BOOTH_DP_GUARD_BIT_EN
    mult(8'h80, 8'h80, 8'h40, 8'h00, "mul_m128xm128");
    mult(8'h7F, 8'h80, 8'hC0, 8'h80, "mul_127xm128");
`endif

    // Load together with a shift: only the load takes effect.
    drive(7'b0000001, 8'h11); tick(-1, -1, -1, -1, "ld");
    drive(7'b0010001, 8'hB3); tick(-1, -1, -1, -1, "ld_shift");
    drive(7'b1000000, 8'h00); tick(8'hB3, 0, 1, 0, "ld_shift_q");
    drive(7'b0100000, 8'h00); tick(8'h00, 0, -1, -1, "ld_shift_a");
    for (int i = 0; i < 7; i++) begin
      drive(7'b0010000, 8'h00); tick(-1, 0, -1, -1, "ld_shift_cnt");
    end
    drive(7'b0000000, 8'h00); tick(-1, 1, -1, -1, "ld_shift_cnt7");

    // Reset after the third shift of 5x3.
    drive(7'b0000001, 8'd5); tick(-1, -1, -1, -1, "rst_mid");
    drive(7'b0000010, 8'd3); tick(-1, -1, -1, -1, "rst_mid");
    for (int i = 0; i < 3; i++) begin
      if ((mq & 1) == 1 && mqm1 == 0) begin
        drive(7'b0001100, 8'h00); tick(-1, -1, -1, -1, "rst_mid");
      end else if ((mq & 1) == 0 && mqm1 == 1) begin
        drive(7'b0000100, 8'h00); tick(-1, -1, -1, -1, "rst_mid");
      end
      drive(7'b0010000, 8'h00); tick(-1, 0, -1, -1, "rst_mid");
    end
    rst = 1'b1;
    drive(7'b0010101, 8'hFF); tick(-1, -1, -1, -1, "rst_mid");
    rst = 1'b0;
    drive(7'b0100000, 8'h00); tick(0, 0, 0, 0, "rst_mid_a");
    drive(7'b1000000, 8'h00); tick(0, 0, 0, 0, "rst_mid_q");
    drive(7'b0000100, 8'h00); tick(-1, -1, -1, -1, "rst_mid_m");
    drive(7'b0100000, 8'h00); tick(0, -1, -1, -1, "rst_mid_m_zero");

    // c3 without c2 leaves A alone.
    drive(7'b0000001, 8'h00); tick(-1, -1, -1, -1, "c3_alone");
    drive(7'b0000010, 8'd9); tick(-1, -1, -1, -1, "c3_alone");
    drive(7'b0000100, 8'h00); tick(-1, -1, -1, -1, "c3_alone");
    drive(7'b0001000, 8'h00); tick(-1, -1, -1, -1, "c3_alone");
    drive(7'b0100000, 8'h00); tick(8'd9, -1, -1, -1, "c3_alone_a");
    drive(7'b1100000, 8'h00); tick(8'd9, -1, -1, -1, "c5_over_c6");

    // Random products against plain arithmetic.
    for (int n = 0; n < 24; n++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
`ifndef BOOTH_DP_GUARD_BIT_EN
      if (y == 8'h80) y = 8'h81;
`endif
      mult_arith(x, y, "mul_rand");
    end

    // Random strobes, operands and occasional resets against the model.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) < 3);
      c = 7'h00;
      for (int b = 0; b < 7; b++) c[b] = ($urandom_range(0, 3) == 0);
      inbus = 8'($urandom_range(0, 255));
      tick(-1, -1, -1, -1, "rand");
    end
    rst = 1'b0;
    drive(7'b0000000, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
